// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite ROM among NUM_REQ requesters, returning ID-tagged reads.
// Round-robin by default; define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      rd_valid,
    output logic [ID_W-1:0]           rd_id,
    output logic [DATA_W-1:0]         rd_data
);
    logic [NUM_REQ-1:0][ADDR_W-1:0] addrs;
    logic [ID_W-1:0]                start, win, idx;
    logic                           found;
    logic [ADDR_W-1:0]              last_addr;
    logic [ROM_LAT-1:0]             pipe_v;
    logic [ROM_LAT-1:0][ID_W-1:0]   pipe_id;

    assign addrs = req_addr;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [ID_W-1:0] ptr;
    assign start = ptr;
    always_ff @(posedge vga_clk or negedge reset_n)
        if (!reset_n) ptr <= '0;
        else if (found) ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(start) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        found = found && reset_n;
    end

    assign gnt         = found ? NUM_REQ'(1) << win : '0;
    assign rom_address = found ? addrs[win] : last_addr;

    // pipe_v/pipe_id shift in at index 0; the tail lines up with rom_q of the same grant
    always_ff @(posedge vga_clk or negedge reset_n)
        if (!reset_n) begin
            last_addr <= '0;
            pipe_v    <= '0;
            pipe_id   <= '0;
            rd_valid  <= 1'b0;
            rd_id     <= '0;
            rd_data   <= '0;
        end else begin
            if (found) last_addr <= addrs[win];
            pipe_v   <= ROM_LAT'({pipe_v, found});
            pipe_id  <= (ROM_LAT * ID_W)'({pipe_id, win});
            rd_valid <= pipe_v[ROM_LAT-1];
            if (pipe_v[ROM_LAT-1]) begin
                rd_id   <= pipe_id[ROM_LAT-1];
                rd_data <= rom_q;
            end
        end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: checks two instances (ROM_LAT 1 and 3) against a cycle-indexed behavioural model.
module tb_sprite_rom_arbiter;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic             vga_clk = 1'b0;
    logic             reset_n;
    logic [3:0]       req;
    logic [39:0]      req_addr;
    logic [1:0][3:0]  gnt_o;
    logic [1:0][9:0]  adr_o;
    logic [1:0][7:0]  q_i;
    logic [1:0]       vld_o;
    logic [1:0][1:0]  id_o;
    logic [1:0][7:0]  dat_o;
    logic [7:0]       q3a, q3b;
    int               total = 0, bad = 0, cyc = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter #(.ROM_LAT(1)) u1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .gnt(gnt_o[0]), .rom_address(adr_o[0]), .rom_q(q_i[0]),
        .rd_valid(vld_o[0]), .rd_id(id_o[0]), .rd_data(dat_o[0]));

    sprite_rom_arbiter #(.ROM_LAT(3)) u3 (
        .vga_clk(vga_clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .gnt(gnt_o[1]), .rom_address(adr_o[1]), .rom_q(q_i[1]),
        .rd_valid(vld_o[1]), .rd_id(id_o[1]), .rd_data(dat_o[1]));

    function automatic logic [7:0] f(input logic [9:0] a);
        return 8'(a * 7 + (a >> 5)) ^ 8'hA5;
    endfunction

    always @(posedge vga_clk) begin
        q_i[0] <= f(adr_o[0]);
        q3a    <= f(adr_o[1]);
        q3b    <= q3a;
        q_i[1] <= q3b;
        cyc    <= cyc + 1;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    // Behavioural model: reads are scheduled into a ring indexed by the cycle they must appear in.
    int          lat[2] = '{1, 3};
    int          mptr = 0;
    logic [9:0]  mlast = '0;
    bit          ev[2][64];
    logic [1:0]  eid[2][64];
    logic [7:0]  edat[2][64];
    logic [1:0]  hid[2];
    logic [7:0]  hdat[2];

    always @(negedge vga_clk) begin
        int w, s, i;
        logic [3:0] eg;
        logic [9:0] ea;
        w = -1;
        if (!reset_n) begin
            mptr  = 0;
            mlast = '0;
            for (int n = 0; n < 2; n++) begin
                hid[n]  = '0;
                hdat[n] = '0;
                for (int j = 0; j < 64; j++) ev[n][j] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                i = FIXED ? k : (mptr + k) % 4;
                if (w < 0 && req[i]) w = i;
            end
        end
        eg = (w >= 0) ? 4'(1 << w) : 4'b0;
        ea = (w >= 0) ? req_addr[w*10 +: 10] : mlast;
        s  = cyc % 64;
        for (int n = 0; n < 2; n++) begin
            chk("gnt", 32'(gnt_o[n]), 32'(eg));
            chk("rom_address", 32'(adr_o[n]), 32'(ea));
            chk("rd_valid", 32'(vld_o[n]), 32'(ev[n][s]));
            if (ev[n][s]) begin
                hid[n]  = eid[n][s];
                hdat[n] = edat[n][s];
            end
            chk("rd_id", 32'(id_o[n]), 32'(hid[n]));
            chk("rd_data", 32'(dat_o[n]), 32'(hdat[n]));
            ev[n][s] = 1'b0;
        end
        if (w >= 0) begin
            mlast = ea;
            mptr  = (w + 1) % 4;
            for (int n = 0; n < 2; n++) begin
                s = (cyc + lat[n] + 1) % 64;
                ev[n][s]   = 1'b1;
                eid[n][s]  = 2'(w);
                edat[n][s] = f(ea);
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [39:0] a, input logic rn = 1'b1);
        @(posedge vga_clk);
        #1;
        req      = r;
        req_addr = a;
        reset_n  = rn;
    endtask

    function automatic logic [39:0] slot(input int i, input logic [9:0] a);
        return 40'(a) << (i * 10);
    endfunction

    initial begin
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        reset_n  = 1'b0;
        req      = '0;
        req_addr = '0;
        repeat (3) drive(4'b0, 40'b0, 1'b0);
        drive(4'b0, 40'b0);
        repeat (10) begin
            @(negedge vga_clk);
            chk("idle_gnt", 32'(gnt_o[0]), 0);
            chk("idle_addr", 32'(adr_o[0]), 0);
            chk("idle_valid", 32'(vld_o[0]), 0);
            drive(4'b0, 40'b0);
        end
        drive(4'b0100, slot(2, 10'h155));
        @(negedge vga_clk);
        chk("single_gnt", 32'(gnt_o[0]), 32'h4);
        chk("single_addr", 32'(adr_o[0]), 32'h155);
        chk("single_addr_l3", 32'(adr_o[1]), 32'h155);
        drive(4'b0, 40'b0);
        @(negedge vga_clk);
        chk("addr_held", 32'(adr_o[0]), 32'h155);
        chk("early_valid", 32'(vld_o[0]), 0);
        drive(4'b0, 40'b0);
        @(negedge vga_clk);
        chk("lat1_valid", 32'(vld_o[0]), 1);
        chk("lat1_id", 32'(id_o[0]), 2);
        chk("lat1_data", 32'(dat_o[0]), 32'(f(10'h155)));
        chk("lat3_early", 32'(vld_o[1]), 0);
        drive(4'b0, 40'b0);
        @(negedge vga_clk);
        chk("lat1_single_pulse", 32'(vld_o[0]), 0);
        chk("lat3_early2", 32'(vld_o[1]), 0);
        drive(4'b0, 40'b0);
        @(negedge vga_clk);
        chk("lat3_valid", 32'(vld_o[1]), 1);
        chk("lat3_id", 32'(id_o[1]), 2);
        chk("lat3_data", 32'(dat_o[1]), 32'(f(10'h155)));
        drive(4'b0, 40'b0, 1'b0);
        drive(4'b0, 40'b0);
        for (int j = 0; j < 5; j++) begin
            drive(4'hF, 40'({$urandom, $urandom}));
            @(negedge vga_clk);
            chk("rr_all", 32'(gnt_o[0]), 32'(1 << (FIXED ? 0 : exp_rr[j])));
        end
        drive(4'b0010, slot(1, 10'h021));
        drive(4'b1010, slot(1, 10'h022) | slot(3, 10'h3C3));
        @(negedge vga_clk);
        chk("ptr2_first", 32'(gnt_o[0]), FIXED ? 32'h2 : 32'h8);
        drive(4'b1010, slot(1, 10'h023) | slot(3, 10'h3C4));
        @(negedge vga_clk);
        chk("ptr2_second", 32'(gnt_o[0]), 32'h2);
        drive(4'b0010, slot(1, 10'h024));
        drive(4'b1010, slot(1, 10'h025) | slot(3, 10'h3C5));
        drive(4'b0000, 40'b0);
        @(negedge vga_clk);
        chk("dropped_gnt", 32'(gnt_o[0]), 0);
        drive(4'b0001, slot(0, 10'h0AA));
        drive(4'b0010, slot(1, 10'h0BB));
        drive(4'b0, 40'b0, 1'b0);
        @(negedge vga_clk);
        chk("rst_valid", 32'(vld_o[0]), 0);
        drive(4'b0, 40'b0);
        repeat (5) begin
            @(negedge vga_clk);
            chk("post_rst_valid", 32'(vld_o[0] | vld_o[1]), 0);
            drive(4'b0, 40'b0);
        end
        drive(4'hF, 40'({$urandom, $urandom}));
        @(negedge vga_clk);
        chk("post_rst_ptr", 32'(gnt_o[0]), 32'h1);
        repeat (2500)
            drive(4'($urandom), 40'({$urandom, $urandom}), $urandom_range(0, 199) != 0);
        repeat (6) drive(4'b0, 40'b0);
        @(negedge vga_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
